// File: rtl/pipe_csel_pkg.sv
// Shared helpers for the pipelined carry-select adder.
// Segment count and the width/segment divisibility check live here.
package pipe_csel_pkg;

  function automatic int nseg(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit seg_ok(input int w, input int s);
    return (s > 0) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: precomputes both carry-in sums for
// a slice and selects a registered pair with a resolved carry.
module csel_segment
  import pipe_csel_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  output logic [SEG_W:0]   s0_o,
  output logic [SEG_W:0]   s1_o,
  input  logic [SEG_W:0]   p0_i,
  input  logic [SEG_W:0]   p1_i,
  input  logic             c_i,
  output logic [SEG_W:0]   sel_o
);

  assign s0_o = {1'b0, a_i} + {1'b0, b_i};
  assign s1_o = {1'b0, a_i} + {1'b0, b_i}
              + {{SEG_W{1'b0}}, 1'b1};

  assign sel_o = c_i ? p1_i : p0_i;

endmodule

// File: rtl/pipe_csel_adder.sv
// Pipelined carry-select adder, one resolve stage per segment.
// Define PIPE_CSEL_SUB_EN to honour the sub (x - y) input.
module pipe_csel_adder
  import pipe_csel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!seg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
    $error("pipe_csel_adder: WIDTH must be a multiple of SEG_W");
  end

  typedef struct packed {
    logic [SEG_W:0] s1;
    logic [SEG_W:0] s0;
  } pair_t;

  logic [WIDTH-1:0] ye;
  logic             ce;

`ifdef PIPE_CSEL_SUB_EN
  assign ye = sub ? ~y : y;
  assign ce = sub | cin;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign ye = y;
  assign ce = cin;
`endif

  logic            pm;
  logic            adv;
  pair_t           pr_q [NSEG][NSEG];
  logic [NSEG-1:0] v_q;
  logic [NSEG-1:0] c_q;
  logic [NSEG-1:0] pm_q;
  logic [SEG_W:0]  pre0 [NSEG];
  logic [SEG_W:0]  pre1 [NSEG];
  logic [SEG_W:0]  sel  [NSEG];

  logic             ov_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             ovf_q;

  assign pm       = x[WIDTH-1] ^ ye[WIDTH-1];
  assign adv      = !ov_q || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    csel_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i   (x[k*SEG_W +: SEG_W]),
      .b_i   (ye[k*SEG_W +: SEG_W]),
      .s0_o  (pre0[k]),
      .s1_o  (pre1[k]),
      .p0_i  (pr_q[k][k].s0),
      .p1_i  (pr_q[k][k].s1),
      .c_i   (c_q[k]),
      .sel_o (sel[k])
    );
  end

  // Gather resolved low segments plus the last selected one.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NSEG - 1; k++) begin
      sum_d[k*SEG_W +: SEG_W] = pr_q[NSEG-1][k].s0[SEG_W-1:0];
    end
    sum_d[WIDTH-1 -: SEG_W] = sel[NSEG-1][SEG_W-1:0];
  end

  // Pipeline shift: all stages move together when adv is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      pm_q   <= '0;
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int j = 0; j < NSEG; j++) begin
        for (int k = 0; k < NSEG; k++) begin
          pr_q[j][k] <= '0;
        end
      end
    end else if (adv) begin
      v_q[0]  <= in_valid;
      c_q[0]  <= ce;
      pm_q[0] <= pm;
      for (int k = 0; k < NSEG; k++) begin
        pr_q[0][k] <= {pre1[k], pre0[k]};
      end
      for (int j = 1; j < NSEG; j++) begin
        v_q[j]  <= v_q[j-1];
        c_q[j]  <= sel[j-1][SEG_W];
        pm_q[j] <= pm_q[j-1];
        for (int k = 0; k < NSEG; k++) begin
          if (k == j - 1) begin
            pr_q[j][k] <= {sel[j-1], sel[j-1]};
          end else begin
            pr_q[j][k] <= pr_q[j-1][k];
          end
        end
      end
      ov_q   <= v_q[NSEG-1];
      sum_q  <= sum_d;
      cout_q <= sel[NSEG-1][SEG_W];
      ovf_q  <= pm_q[NSEG-1] ^ sel[NSEG-1][SEG_W-1]
              ^ sel[NSEG-1][SEG_W];
    end
  end

  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_csel_adder.sv
// Directed bench for pipe_csel_adder, WIDTH=32 SEG_W=8.
// Latency, overflow, subtract, streaming, backpressure, reset.
module tb_pipe_csel_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_csel_adder #(
    .WIDTH (32),
    .SEG_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {cout, ovf, sum}.
  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic c,
                                        input logic s);
    logic [31:0] be;
    logic        ce;
    logic [32:0] r;
    logic        v;
    be = b;
    ce = c;
`ifdef PIPE_CSEL_SUB_EN
    if (s) begin
      be = ~b;
      ce = 1'b1;
    end
`else
    if (s) begin
      be = b;
    end
`endif
    r = {1'b0, a} + {1'b0, be} + {32'd0, ce};
    v = (a[31] == be[31]) && (r[31] != a[31]);
    return {r[32], v, r[31:0]};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    in_valid = 1'b1;
    x = a;
    y = b;
    cin = c;
    sub = s;
  endtask

  // Caller sits just after an edge; checks exact 4-edge latency.
  task automatic run_one(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic c,
                         input logic s, input logic [31:0] esum,
                         input logic ecout, input logic eovf);
    drive(a, b, c, s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sub = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) chk({tag, "_early"}, 64'(out_valid), 64'd0);
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(esum));
    chk({tag, "_cout"}, 64'(cout), 64'(ecout));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    @(posedge clk); #1;
  endtask

  logic [31:0] xs [16];
  logic [31:0] ys [16];
  logic        cs [16];
  logic [33:0] es [16];
  logic [31:0] bx [6];
  logic [31:0] by [6];
  logic [33:0] eb [6];

  initial begin
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0,
            32'h0000_0000, 1'b1, 1'b0);
    run_one("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
            32'h8000_0000, 1'b0, 1'b1);
    run_one("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
            32'h0000_0000, 1'b1, 1'b1);
    run_one("segcarry", 32'h0000_00FF, 32'h1, 1'b0, 1'b0,
            32'h0000_0100, 1'b0, 1'b0);
    run_one("mixed", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
            32'h2345_678A, 1'b0, 1'b0);
`ifdef PIPE_CSEL_SUB_EN
    run_one("sub", 32'd5, 32'd7, 1'b0, 1'b1,
            32'hFFFF_FFFE, 1'b0, 1'b0);
`else
    run_one("sub", 32'd5, 32'd7, 1'b0, 1'b1,
            32'h0000_000C, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 16; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
      cs[i] = 1'($urandom_range(0, 1));
      es[i] = model(xs[i], ys[i], cs[i], 1'b0);
    end
    drive(xs[0], ys[0], cs[0], 1'b0);
    for (int c = 0; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 3 || c == 20) begin
        chk("strm_gap", 64'(out_valid), 64'd0);
      end else if (c >= 4) begin
        chk("strm_valid", 64'(out_valid), 64'd1);
        chk("strm_res", 64'({cout, ovf, sum}), 64'(es[c-4]));
      end
      if (c + 1 < 16) drive(xs[c+1], ys[c+1], cs[c+1], 1'b0);
      else in_valid = 1'b0;
    end

    for (int i = 0; i < 6; i++) begin
      bx[i] = 32'h0101_0101 * (i + 3);
      by[i] = 32'hF0F0_0F0F - 32'(i);
      eb[i] = model(bx[i], by[i], 1'b0, 1'b0);
    end
    out_ready = 1'b0;
    drive(bx[0], by[0], 1'b0, 1'b0);
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 3) chk("bp_noidle_stall", 64'(in_ready), 64'd1);
      drive(bx[e+1], by[e+1], 1'b0, 1'b0);
    end
    for (int s = 0; s < 3; s++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'({cout, ovf, sum}), 64'(eb[0]));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("bp_drain_valid", 64'(out_valid), 64'd1);
      chk("bp_drain_res", 64'({cout, ovf, sum}), 64'(eb[k]));
      @(posedge clk); #1;
    end
    chk("bp_empty", 64'(out_valid), 64'd0);

    for (int e = 0; e <= 4; e++) begin
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF - 32'(e), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rm_pre_valid", 64'(out_valid), 64'd1);
    chk("rm_pre_sum", 64'(sum), 64'hFFFF_FFFE);
    rst_n = 1'b0;
    #1;
    chk("rm_valid", 64'(out_valid), 64'd0);
    chk("rm_sum", 64'(sum), 64'd0);
    chk("rm_cout", 64'(cout), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("rm_no_stale", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
